// File: rtl/mult_pkg.sv
// -----------------------------------------------------------------------------
// mult_pkg
//   Shared definitions for the shift-and-add integer multiplier:
//   - CS_W      : default width of the cs state-debug output
//   - state_e   : controller state encoding, visible on the cs port
//   - count_width(): width of the iteration counter for an N-bit operand
// -----------------------------------------------------------------------------
package mult_pkg;

    localparam int CS_W = 4;

    // Codes 6..15 are illegal; the controller recovers from them to IDLE.
    typedef enum logic [CS_W-1:0] {
        IDLE  = 4'd0,
        LOAD  = 4'd1,
        TEST  = 4'd2,
        ADD   = 4'd3,
        SHIFT = 4'd4,
        DONE  = 4'd5
    } state_e;

    // The counter must hold the value N itself, so it needs clog2(N+1) bits.
    function automatic int count_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/integer_multiplier_dp.sv
// -----------------------------------------------------------------------------
// integer_multiplier_dp
//   Datapath of the shift-and-add multiplier. Holds the accumulator, the
//   shifted multiplicand (areg), the shifted multiplier (breg), the iteration
//   counter and the registered product. Driven by one-hot strobes from the
//   controller.
//
//   clk, rst        : clock, synchronous active-high reset
//   load_i          : clear acc, capture operands, count <= N
//   add_i           : acc += areg, then shift areg/breg and decrement count
//   shift_i         : shift areg/breg and decrement count, no accumulate
//   latch_i         : product <= acc
//   multiplicand_i  : operand A (N bits, unsigned)
//   multiplier_i    : operand B (N bits, unsigned)
//   product_o       : registered 2N-bit product
//   count_zero_o    : all N iterations have been performed
//   b_lsb_o         : current multiplier bit under test
// -----------------------------------------------------------------------------
module integer_multiplier_dp
    import mult_pkg::*;
#(
    parameter int N = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           load_i,
    input  logic           add_i,
    input  logic           shift_i,
    input  logic           latch_i,
    input  logic [N-1:0]   multiplicand_i,
    input  logic [N-1:0]   multiplier_i,
    output logic [2*N-1:0] product_o,
    output logic           count_zero_o,
    output logic           b_lsb_o
);

    localparam int CNT_W = count_width(N);

    logic [2*N-1:0]   acc_q,     acc_d;
    logic [2*N-1:0]   areg_q,    areg_d;
    logic [N-1:0]     breg_q,    breg_d;
    logic [CNT_W-1:0] count_q,   count_d;
    logic [2*N-1:0]   product_q, product_d;

    // NOTE: every combinational output is given its hold value first, so no
    // path through the branches below leaves a signal unassigned (no latch).
    always_comb begin
        acc_d     = acc_q;
        areg_d    = areg_q;
        breg_d    = breg_q;
        count_d   = count_q;
        product_d = product_q;

        if (load_i) begin
            acc_d   = '0;
            areg_d  = {{N{1'b0}}, multiplicand_i};
            breg_d  = multiplier_i;
            count_d = CNT_W'(N);
        end else if (add_i || shift_i) begin
            // acc never exceeds (2^N-1)^2, so the 2N-bit sum cannot overflow.
            if (add_i) begin
                acc_d = acc_q + areg_q;
            end
            areg_d  = areg_q << 1;
            breg_d  = breg_q >> 1;
            // The controller checks count==0 before every step, so no wrap.
            count_d = count_q - CNT_W'(1);
        end

        if (latch_i) begin
            product_d = acc_q;
        end
    end

    // NOTE: state registers use non-blocking assignments so all of them
    // update together from the values present before the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q     <= '0;
            areg_q    <= '0;
            breg_q    <= '0;
            count_q   <= '0;
            product_q <= '0;
        end else begin
            acc_q     <= acc_d;
            areg_q    <= areg_d;
            breg_q    <= breg_d;
            count_q   <= count_d;
            product_q <= product_d;
        end
    end

    assign product_o    = product_q;
    assign count_zero_o = (count_q == '0);
    assign b_lsb_o      = breg_q[0];

endmodule

// File: rtl/integer_multiplier.sv
// -----------------------------------------------------------------------------
// integer_multiplier
//   Sequential unsigned shift-and-add multiplier with a go/done handshake.
//   Latency is fixed: done rises 2N+3 edges after (and including) the edge
//   that samples go=1. One operation is in flight at a time; only rst aborts.
//
//   clk           : clock, all state changes on the rising edge
//   rst           : synchronous active-high reset, priority over go
//   go            : start request, sampled in IDLE and DONE
//   multiplicand  : operand A (N bits), stable from go-sampling edge to LOAD
//   multiplier    : operand B (N bits), same stability window
//   product       : registered 2N-bit product, updated on entry to DONE
//   done          : high while in DONE
//   busy          : high in LOAD/TEST/ADD/SHIFT
//   cs            : current state code (see mult_pkg::state_e)
// -----------------------------------------------------------------------------
module integer_multiplier
    import mult_pkg::*;
#(
    parameter int N    = 4,
    parameter int CS_W = mult_pkg::CS_W
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            go,
    input  logic [N-1:0]    multiplicand,
    input  logic [N-1:0]    multiplier,
    output logic [2*N-1:0]  product,
    output logic            done,
    output logic            busy,
    output logic [CS_W-1:0] cs
);

    state_e state_q, state_d;

    logic load, add, shift, latch;
    logic count_zero, b_lsb;

    // Next-state logic.
    always_comb begin
        state_d = IDLE;
        case (state_q)
            IDLE:    state_d = go ? LOAD : IDLE;
            LOAD:    state_d = TEST;
            TEST: begin
                if (count_zero) begin
                    state_d = DONE;
                end else if (b_lsb) begin
                    state_d = ADD;
                end else begin
                    state_d = SHIFT;
                end
            end
            ADD:     state_d = TEST;
            SHIFT:   state_d = TEST;
            DONE:    state_d = go ? LOAD : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath strobes and status outputs are pure decodes of the state.
    always_comb begin
        load  = (state_q == LOAD);
        add   = (state_q == ADD);
        shift = (state_q == SHIFT);
        latch = (state_q == TEST) && count_zero;
        done  = (state_q == DONE);
        busy  = (state_q == LOAD) || (state_q == TEST) ||
                (state_q == ADD)  || (state_q == SHIFT);
    end

    assign cs = CS_W'(state_q);

    integer_multiplier_dp #(
        .N (N)
    ) u_dp (
        .clk            (clk),
        .rst            (rst),
        .load_i         (load),
        .add_i          (add),
        .shift_i        (shift),
        .latch_i        (latch),
        .multiplicand_i (multiplicand),
        .multiplier_i   (multiplier),
        .product_o      (product),
        .count_zero_o   (count_zero),
        .b_lsb_o        (b_lsb)
    );

endmodule

// File: tb/tb_integer_multiplier.sv
// -----------------------------------------------------------------------------
// tb_integer_multiplier
//   Self-checking bench for integer_multiplier (N=4). Expected products are
//   pushed to a scoreboard queue when an operation starts and popped when
//   done is observed. Inputs change and outputs are sampled 1 time unit after
//   the rising edge.
// -----------------------------------------------------------------------------
module tb_integer_multiplier;

    localparam int N       = 4;
    localparam int CS_W    = 4;
    localparam int LATENCY = 2 * N + 3;

    logic            clk;
    logic            rst;
    logic            go;
    logic [N-1:0]    multiplicand;
    logic [N-1:0]    multiplier;
    logic [2*N-1:0]  product;
    logic            done;
    logic            busy;
    logic [CS_W-1:0] cs;

    int total = 0;
    int bad   = 0;

    logic [2*N-1:0] sb[$];

    integer_multiplier #(
        .N    (N),
        .CS_W (CS_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .go           (go),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .product      (product),
        .done         (done),
        .busy         (busy),
        .cs           (cs)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Starts one operation from IDLE or DONE and waits for done.
    // Called just after a rising edge; returns just after the edge entering DONE.
    task automatic do_op(input logic [N-1:0] a, input logic [N-1:0] b,
                         input bit keep_go, input string tag, output bit ok);
        int             edges;
        bit             held;
        logic [2*N-1:0] prev;
        logic [2*N-1:0] exp;
        ok   = 1'b1;
        held = 1'b1;
        prev = product;
        multiplicand = a;
        multiplier   = b;
        go           = 1'b1;
        sb.push_back((2*N)'(a) * (2*N)'(b));

        tick();
        edges = 1;
        total++;
        if (cs !== 4'd1 || busy !== 1'b1 || done !== 1'b0) begin
            bad++; ok = 1'b0;
            $display("FAIL %s load: cs=%0d busy=%b done=%b, want cs=1 busy=1 done=0",
                     tag, cs, busy, done);
        end
        if (!keep_go) go = 1'b0;

        while (done !== 1'b1 && edges < 40) begin
            if (product !== prev) held = 1'b0;
            tick();
            edges++;
        end

        exp = (sb.size() > 0) ? sb.pop_front() : 'x;
        total++;
        if (!held) begin
            bad++; ok = 1'b0;
            $display("FAIL %s hold: product changed before done, was %0d", tag, prev);
        end
        total++;
        if (edges !== LATENCY) begin
            bad++; ok = 1'b0;
            $display("FAIL %s latency: got %0d edges, want %0d", tag, edges, LATENCY);
        end
        total++;
        if (product !== exp) begin
            bad++; ok = 1'b0;
            $display("FAIL %s product: %0d*%0d got %0d, want %0d", tag, a, b, product, exp);
        end
        total++;
        if (cs !== 4'd5 || busy !== 1'b0) begin
            bad++; ok = 1'b0;
            $display("FAIL %s done_state: cs=%0d busy=%b, want cs=5 busy=0", tag, cs, busy);
        end
    endtask

    task automatic test_reset();
        // Put the DUT somewhere mid-operation, then reset for two edges.
        rst = 1'b0;
        multiplicand = 4'd5;
        multiplier   = 4'd7;
        go = 1'b1;
        repeat (4) tick();
        go  = 1'b0;
        rst = 1'b1;
        repeat (2) tick();
        total++;
        if (cs !== 4'd0 || done !== 1'b0 || busy !== 1'b0 || product !== 8'd0) begin
            bad++;
            $display("FAIL reset: cs=%0d done=%b busy=%b product=%0d, want 0 0 0 0",
                     cs, done, busy, product);
        end
        rst = 1'b0;
        tick();
        total++;
        if (cs !== 4'd0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_idle: cs=%0d busy=%b, want cs=0 busy=0", cs, busy);
        end
    endtask

    task automatic test_single();
        bit ok;
        do_op(4'd3, 4'd5, 1'b0, "single", ok);
        tick();
        total++;
        if (cs !== 4'd0 || done !== 1'b0 || product !== 8'd15) begin
            bad++;
            $display("FAIL single_after: cs=%0d done=%b product=%0d, want cs=0 done=0 product=15",
                     cs, done, product);
        end
    endtask

    task automatic test_boundaries();
        bit ok;
        do_op(4'd15, 4'd15, 1'b0, "bnd_15x15", ok);
        tick();
        do_op(4'd0, 4'd9, 1'b0, "bnd_0x9", ok);
        tick();
        do_op(4'd9, 4'd0, 1'b0, "bnd_9x0", ok);
        tick();
        do_op(4'd1, 4'd15, 1'b0, "bnd_1x15", ok);
        tick();
    endtask

    task automatic test_back_to_back();
        bit ok;
        do_op(4'd7, 4'd6, 1'b1, "b2b_first", ok);
        // Second op starts from DONE; its LOAD check shows DONE->LOAD and done low.
        do_op(4'd12, 4'd11, 1'b0, "b2b_second", ok);
        tick();
        total++;
        if (cs !== 4'd0 || done !== 1'b0 || product !== 8'd132) begin
            bad++;
            $display("FAIL b2b_after: cs=%0d done=%b product=%0d, want cs=0 done=0 product=132",
                     cs, done, product);
        end
    endtask

    task automatic test_reset_mid_op();
        int guard;
        bit ok;
        multiplicand = 4'd13;
        multiplier   = 4'd13;
        go = 1'b1;
        tick();
        go = 1'b0;
        guard = 0;
        while (cs !== 4'd3 && guard < 20) begin
            tick();
            guard++;
        end
        total++;
        if (cs !== 4'd3) begin
            bad++;
            $display("FAIL midrst_reach_add: cs=%0d, want 3", cs);
        end
        rst = 1'b1;
        tick();
        total++;
        if (cs !== 4'd0 || done !== 1'b0 || busy !== 1'b0 || product !== 8'd0) begin
            bad++;
            $display("FAIL midrst: cs=%0d done=%b busy=%b product=%0d, want 0 0 0 0",
                     cs, done, busy, product);
        end
        rst = 1'b0;
        sb.delete();
        tick();
        do_op(4'd2, 4'd3, 1'b0, "midrst_after", ok);
        tick();
    endtask

    task automatic test_exhaustive();
        bit ok;
        bit stop;
        stop = 1'b0;
        for (int a = 0; a < 16 && !stop; a++) begin
            for (int b = 0; b < 16 && !stop; b++) begin
                do_op(N'(a), N'(b), 1'b1, "exh", ok);
                if (!ok) stop = 1'b1;
            end
        end
        go = 1'b0;
        tick();
    endtask

    initial begin
        rst          = 1'b1;
        go           = 1'b0;
        multiplicand = '0;
        multiplier   = '0;
        tick();

        test_reset();
        test_single();
        test_boundaries();
        test_back_to_back();
        test_reset_mid_op();
        test_exhaustive();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
